// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus: instruction memory read port, decoder handshake and branch input.
// The fetch unit connects through the master modport; memory/decoder/ALU side uses slave.
interface instruction_fetch_unit_if;
  logic [15:0] O_mem_addr;
  logic        O_mem_rd_en;
  logic [15:0] I_mem_data;
  logic        I_mem_valid;
  logic [15:0] O_instruction;
  logic [15:0] O_pc;
  logic        O_instr_valid;
  logic        I_instr_ready;
  logic        I_should_branch;
  logic [15:0] I_branch_addr;
  logic        O_fetch_err;

  modport master (
    output O_mem_addr, O_mem_rd_en, O_instruction, O_pc, O_instr_valid, O_fetch_err,
    input  I_mem_data, I_mem_valid, I_instr_ready, I_should_branch, I_branch_addr
  );

  modport slave (
    input  O_mem_addr, O_mem_rd_en, O_instruction, O_pc, O_instr_valid, O_fetch_err,
    output I_mem_data, I_mem_valid, I_instr_ready, I_should_branch, I_branch_addr
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues one read per instruction, holds the fetched word
// until the decoder accepts it, flushes on branches and reissues on memory timeout.
// All state updates on the falling edge of I_clk.
module instruction_fetch_unit #(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int unsigned TIMEOUT      = 8
) (
  input logic                          I_clk,
  input logic                          I_rst_n,
  instruction_fetch_unit_if.master     bus
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_e;

  localparam logic [7:0] TmoLast = 8'(TIMEOUT - 1);

  state_e      state;
  logic [15:0] fetch_pc;
  logic [7:0]  tmo_cnt;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == TmoLast);

  // Fetch FSM with registered outputs; branch overrides everything except reset.
  always_ff @(negedge I_clk) begin
    if (!I_rst_n) begin
      state             <= S_REQ;
      fetch_pc          <= RESET_VECTOR;
      tmo_cnt           <= 8'd0;
      bus.O_mem_addr    <= RESET_VECTOR;
      bus.O_mem_rd_en   <= 1'b0;
      bus.O_instruction <= 16'h0000;
      bus.O_pc          <= RESET_VECTOR;
      bus.O_instr_valid <= 1'b0;
      bus.O_fetch_err   <= 1'b0;
    end else begin
      bus.O_mem_rd_en <= 1'b0;
      if (bus.I_should_branch) begin
        fetch_pc          <= bus.I_branch_addr;
        bus.O_instr_valid <= 1'b0;
        case (state)
          // A request is still in flight unless its data lands on this very edge.
          S_WAIT:  state <= bus.I_mem_valid ? S_REQ : S_DROP;
          S_DROP:  state <= S_DROP;
          default: state <= S_REQ;
        endcase
      end else begin
        unique case (state)
          S_REQ: begin
            bus.O_mem_addr  <= fetch_pc;
            bus.O_mem_rd_en <= 1'b1;
            tmo_cnt         <= 8'd0;
            state           <= S_WAIT;
          end
          S_WAIT: begin
            if (bus.I_mem_valid) begin
              bus.O_instruction <= bus.I_mem_data;
              bus.O_pc          <= fetch_pc;
              bus.O_instr_valid <= 1'b1;
              fetch_pc          <= fetch_pc + 16'd1;
              state             <= S_HOLD;
            end else if (tmo_hit) begin
              // fetch_pc untouched so the same address is requested again.
              bus.O_fetch_err <= 1'b1;
              state           <= S_REQ;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
          S_HOLD: begin
            if (bus.I_instr_ready) begin
              bus.O_instr_valid <= 1'b0;
              bus.O_mem_addr    <= fetch_pc;
              bus.O_mem_rd_en   <= 1'b1;
              tmo_cnt           <= 8'd0;
              state             <= S_WAIT;
            end
          end
          S_DROP: begin
            // Stale response from before the branch: swallow it or give up on timeout.
            if (bus.I_mem_valid) begin
              state <= S_REQ;
            end else if (tmo_hit) begin
              bus.O_fetch_err <= 1'b1;
              state           <= S_REQ;
            end else begin
              tmo_cnt <= tmo_cnt + 8'd1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus a randomized run
// compared every edge against a request/response level model.
module tb_instruction_fetch_unit;
  localparam int TMO = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  instruction_fetch_unit_if bus ();

  instruction_fetch_unit #(
    .RESET_VECTOR (16'h0000),
    .TIMEOUT      (TMO)
  ) dut (
    .I_clk   (clk),
    .I_rst_n (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1);
  end

  // Model: tracks whether a read is outstanding, whether its data is unwanted,
  // how long it has been outstanding, and the instruction buffer seen by the decoder.
  logic [15:0] m_pc, m_addr, m_instr, m_opc;
  logic        m_rd, m_valid, m_err;
  bit          m_pend, m_disc;
  int          m_age;

  task automatic model_issue();
    m_addr = m_pc; m_rd = 1'b1; m_pend = 1; m_disc = 0; m_age = 0;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_pc = 16'h0; m_addr = 16'h0; m_instr = 16'h0; m_opc = 16'h0;
      m_rd = 0; m_valid = 0; m_err = 0; m_pend = 0; m_disc = 0; m_age = 0;
      return;
    end
    m_rd = 1'b0;
    if (bus.I_should_branch) begin
      m_pc = bus.I_branch_addr;
      m_valid = 0;
      if (m_pend && !m_disc) begin
        if (bus.I_mem_valid) m_pend = 0;
        else m_disc = 1;
      end
    end else if (m_pend) begin
      if (bus.I_mem_valid) begin
        if (!m_disc) begin
          m_instr = bus.I_mem_data; m_opc = m_pc; m_valid = 1; m_pc = m_pc + 16'd1;
        end
        m_pend = 0; m_disc = 0;
      end else if (m_age == TMO - 1) begin
        m_err = 1; m_pend = 0; m_disc = 0;
      end else begin
        m_age++;
      end
    end else if (m_valid) begin
      if (bus.I_instr_ready) begin
        m_valid = 0;
        model_issue();
      end
    end else begin
      model_issue();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic br, input logic [15:0] baddr, input logic mv,
                        input logic [15:0] mdata, input logic rdy);
    bus.I_should_branch = br; bus.I_branch_addr = baddr;
    bus.I_mem_valid = mv; bus.I_mem_data = mdata; bus.I_instr_ready = rdy;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_in(0, 16'h0, 0, 16'h0, 0);
    tick(); tick();
    checks += 6;
    if (bus.O_mem_addr !== 16'h0) begin errors++;
      $display("FAIL reset_addr got %h want 0000", bus.O_mem_addr); end
    if (bus.O_mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL reset_rd got %b want 0", bus.O_mem_rd_en); end
    if (bus.O_instr_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got %b want 0", bus.O_instr_valid); end
    if (bus.O_instruction !== 16'h0) begin errors++;
      $display("FAIL reset_instr got %h want 0000", bus.O_instruction); end
    if (bus.O_pc !== 16'h0) begin errors++;
      $display("FAIL reset_pc got %h want 0000", bus.O_pc); end
    if (bus.O_fetch_err !== 1'b0) begin errors++;
      $display("FAIL reset_err got %b want 0", bus.O_fetch_err); end
  endtask

  task automatic test_normal_fetch();
    rst_n = 1'b1;
    set_in(0, 16'h0, 0, 16'h0, 1);
    tick();
    checks += 2;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h0000) begin errors++;
      $display("FAIL first_req got rd=%b addr=%h want rd=1 addr=0000",
               bus.O_mem_rd_en, bus.O_mem_addr); end
    set_in(0, 16'h0, 1, 16'h8F0F, 1);
    tick();
    if (bus.O_instr_valid !== 1'b1 || bus.O_instruction !== 16'h8F0F || bus.O_pc !== 16'h0
        || bus.O_mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL fetch_data got v=%b i=%h pc=%h rd=%b want v=1 i=8f0f pc=0000 rd=0",
               bus.O_instr_valid, bus.O_instruction, bus.O_pc, bus.O_mem_rd_en); end
    set_in(0, 16'h0, 0, 16'h0, 1);
    tick();
    checks += 1;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h0001 || bus.O_instr_valid !== 1'b0)
    begin errors++;
      $display("FAIL next_req got rd=%b addr=%h v=%b want rd=1 addr=0001 v=0",
               bus.O_mem_rd_en, bus.O_mem_addr, bus.O_instr_valid); end
  endtask

  task automatic test_stall();
    set_in(0, 16'h0, 1, 16'h1234, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 16'h0, i[0], 16'hFFFF, 0);
      tick();
      checks++;
      if (bus.O_instr_valid !== 1'b1 || bus.O_instruction !== 16'h1234 || bus.O_pc !== 16'h0001
          || bus.O_mem_rd_en !== 1'b0) begin errors++;
        $display("FAIL stall_hold[%0d] got v=%b i=%h pc=%h rd=%b want v=1 i=1234 pc=0001 rd=0",
                 i, bus.O_instr_valid, bus.O_instruction, bus.O_pc, bus.O_mem_rd_en); end
    end
    set_in(0, 16'h0, 0, 16'h0, 1);
    tick();
    checks++;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h0002) begin errors++;
      $display("FAIL stall_release got rd=%b addr=%h want rd=1 addr=0002",
               bus.O_mem_rd_en, bus.O_mem_addr); end
  endtask

  task automatic test_branch_flush();
    set_in(1, 16'h000B, 0, 16'h0, 0);
    tick();
    set_in(0, 16'h0, 1, 16'hDEAD, 0);
    tick();
    checks++;
    if (bus.O_instr_valid !== 1'b0 || bus.O_mem_rd_en !== 1'b0) begin errors++;
      $display("FAIL flush_discard got v=%b rd=%b want v=0 rd=0",
               bus.O_instr_valid, bus.O_mem_rd_en); end
    set_in(0, 16'h0, 0, 16'h0, 0);
    tick();
    checks++;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h000B || bus.O_instr_valid !== 1'b0)
    begin errors++;
      $display("FAIL flush_target got rd=%b addr=%h v=%b want rd=1 addr=000b v=0",
               bus.O_mem_rd_en, bus.O_mem_addr, bus.O_instr_valid); end
  endtask

  task automatic test_timeout();
    set_in(0, 16'h0, 0, 16'h0, 0);
    for (int i = 1; i < TMO; i++) begin
      tick();
      checks++;
      if (bus.O_fetch_err !== 1'b0 || bus.O_mem_rd_en !== 1'b0) begin errors++;
        $display("FAIL tmo_early[%0d] got err=%b rd=%b want err=0 rd=0",
                 i, bus.O_fetch_err, bus.O_mem_rd_en); end
    end
    tick();
    checks++;
    if (bus.O_fetch_err !== 1'b1) begin errors++;
      $display("FAIL tmo_flag got %b want 1", bus.O_fetch_err); end
    tick();
    checks++;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h000B) begin errors++;
      $display("FAIL tmo_reissue got rd=%b addr=%h want rd=1 addr=000b",
               bus.O_mem_rd_en, bus.O_mem_addr); end
  endtask

  task automatic test_wrap();
    set_in(1, 16'hFFFF, 0, 16'h0, 0);
    tick();
    set_in(0, 16'h0, 1, 16'h0BAD, 0);
    tick();
    set_in(0, 16'h0, 0, 16'h0, 0);
    tick();
    checks++;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'hFFFF) begin errors++;
      $display("FAIL wrap_req got rd=%b addr=%h want rd=1 addr=ffff",
               bus.O_mem_rd_en, bus.O_mem_addr); end
    set_in(0, 16'h0, 1, 16'h5A5A, 0);
    tick();
    checks++;
    if (bus.O_pc !== 16'hFFFF || bus.O_instruction !== 16'h5A5A || bus.O_instr_valid !== 1'b1)
    begin errors++;
      $display("FAIL wrap_data got pc=%h i=%h v=%b want pc=ffff i=5a5a v=1",
               bus.O_pc, bus.O_instruction, bus.O_instr_valid); end
    set_in(0, 16'h0, 0, 16'h0, 1);
    tick();
    checks += 2;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h0000) begin errors++;
      $display("FAIL wrap_next got rd=%b addr=%h want rd=1 addr=0000",
               bus.O_mem_rd_en, bus.O_mem_addr); end
    if (bus.O_fetch_err !== 1'b1) begin errors++;
      $display("FAIL err_sticky got %b want 1", bus.O_fetch_err); end
  endtask

  task automatic test_reset_mid();
    set_in(0, 16'h0, 1, 16'h1111, 1);
    tick();
    set_in(0, 16'h0, 0, 16'h0, 1);
    tick();
    set_in(0, 16'h0, 1, 16'h7777, 0);
    tick();
    checks++;
    if (bus.O_instr_valid !== 1'b1 || bus.O_pc !== 16'h0001) begin errors++;
      $display("FAIL mid_hold got v=%b pc=%h want v=1 pc=0001",
               bus.O_instr_valid, bus.O_pc); end
    rst_n = 1'b0;
    set_in(0, 16'h0, 0, 16'h0, 0);
    tick();
    checks++;
    if (bus.O_instr_valid !== 1'b0 || bus.O_pc !== 16'h0 || bus.O_instruction !== 16'h0
        || bus.O_mem_addr !== 16'h0 || bus.O_mem_rd_en !== 1'b0 || bus.O_fetch_err !== 1'b0)
    begin errors++;
      $display("FAIL mid_reset got v=%b pc=%h i=%h addr=%h rd=%b err=%b want all zero",
               bus.O_instr_valid, bus.O_pc, bus.O_instruction, bus.O_mem_addr,
               bus.O_mem_rd_en, bus.O_fetch_err); end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.O_mem_rd_en !== 1'b1 || bus.O_mem_addr !== 16'h0000) begin errors++;
      $display("FAIL mid_restart got rd=%b addr=%h want rd=1 addr=0000",
               bus.O_mem_rd_en, bus.O_mem_addr); end
  endtask

  task automatic test_random();
    int mv_pct;
    int bad;
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      mv_pct = (n < 1500) ? 50 : 8;
      rst_n = ($urandom_range(0, 199) != 0);
      bus.I_should_branch = ($urandom_range(0, 99) < 10);
      bus.I_branch_addr   = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 1))
                                                        : 16'($urandom);
      bus.I_mem_valid     = ($urandom_range(0, 99) < mv_pct);
      bus.I_mem_data      = 16'($urandom);
      bus.I_instr_ready   = ($urandom_range(0, 99) < 50);
      tick();
      checks++;
      if (bus.O_mem_addr !== m_addr || bus.O_mem_rd_en !== m_rd
          || bus.O_instr_valid !== m_valid || bus.O_fetch_err !== m_err
          || bus.O_pc !== m_opc || bus.O_instruction !== m_instr) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] got addr=%h rd=%b v=%b err=%b pc=%h i=%h want addr=%h rd=%b v=%b err=%b pc=%h i=%h",
                   n, bus.O_mem_addr, bus.O_mem_rd_en, bus.O_instr_valid, bus.O_fetch_err,
                   bus.O_pc, bus.O_instruction, m_addr, m_rd, m_valid, m_err, m_opc, m_instr);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_normal_fetch();
    test_stall();
    test_branch_flush();
    test_timeout();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
